// File: rtl/add_buf_pkg.sv
// Shared definitions for the adder result buffer.
//   DefWidth   : default adder result width
//   DefDepth   : default FIFO entry count (power of two, >= 2)
//   DefQualCyc : default number of consecutive locked cycles before data is accepted
//   lock_state_e : lock FSM state type
package add_buf_pkg;

  localparam int unsigned DefWidth   = 32;
  localparam int unsigned DefDepth   = 4;
  localparam int unsigned DefQualCyc = 4;

  // StWaitLock: PLL not locked; StQual: counting locked cycles; StRun: accepting data
  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StQual     = 2'd1,
    StRun      = 2'd2
  } lock_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding the buffered adder results.
//   clk_i   : clock, all updates on rising edge
//   rst_i   : synchronous active-high reset, clears pointers and occupancy
//   push_i  : write wdata_i at the tail (ignored when full)
//   pop_i   : drop the head entry (ignored when empty)
//   wdata_i : data to write
//   rdata_o : head entry, read straight from storage flops (no write bypass)
//   count_o : current occupancy, 0..Depth
module sync_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (count_q != DepthCnt);
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata_i;
      // Depth is a power of two, so the pointer wraps by natural overflow
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q says they are valid
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/add_result_buffer.sv
// Buffers adder results ({OF, sum}) in a FIFO, accepting them only once the PLL
// lock has been stable for QUAL_CYC consecutive cycles.
//   refclk     : single clock
//   rst        : synchronous active-high reset; all outputs read as zero while high
//   locked     : PLL lock indication
//   in_valid   : sum/OF carry a valid adder result
//   sum, OF    : adder result and overflow flag
//   in_ready   : result accepted this cycle (locked-qualified and not full)
//   out_valid  : out_data holds the FIFO head
//   out_ready  : consumer takes the head this cycle
//   out_data   : {OF, sum} of the head entry
//   count      : FIFO occupancy
//   of_count   : saturating count of accepted entries with OF=1
//   drop_count : saturating count of cycles with in_valid=1 and in_ready=0
module add_result_buffer
  import add_buf_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned QUAL_CYC = DefQualCyc
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    locked,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        sum,
  input  logic                    OF,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH:0]          out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic [15:0]             of_count,
  output logic [15:0]             drop_count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned QcW  = (QUAL_CYC < 2) ? 1 : $clog2(QUAL_CYC + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  // Counter value seen in QUAL on the last required locked cycle
  localparam logic [QcW-1:0]  QualLast = QcW'((QUAL_CYC < 2) ? 1 : QUAL_CYC - 1);
  localparam logic [15:0]     SatMax   = 16'hFFFF;

  lock_state_e     state_q, state_d;
  logic [QcW-1:0]  qual_cnt_q, qual_cnt_d;
  logic [15:0]     of_cnt_q, of_cnt_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic            push, pop;
  logic [CntW-1:0] fifo_count;
  logic [WIDTH:0]  fifo_rdata;

  // Lock qualification: the cycle that moves WAIT_LOCK -> QUAL counts as the first
  // locked cycle, so RUN is reached after exactly QUAL_CYC consecutive locked cycles.
  always_comb begin
    state_d    = state_q;
    qual_cnt_d = qual_cnt_q;
    if (!locked) begin
      state_d    = StWaitLock;
      qual_cnt_d = '0;
    end else begin
      unique case (state_q)
        StWaitLock: begin
          if (QUAL_CYC < 2) begin
            state_d = StRun;
          end else begin
            state_d    = StQual;
            qual_cnt_d = QcW'(1);
          end
        end
        StQual: begin
          if (qual_cnt_q >= QualLast) begin
            state_d    = StRun;
            qual_cnt_d = '0;
          end else begin
            qual_cnt_d = qual_cnt_q + QcW'(1);
          end
        end
        StRun: begin
          state_d = StRun;
        end
        default: begin
          state_d    = StWaitLock;
          qual_cnt_d = '0;
        end
      endcase
    end
  end

  // Full blocks acceptance even when a pop happens the same cycle
  always_comb begin
    in_ready  = !rst && (state_q == StRun) && (fifo_count != DepthCnt);
    out_valid = !rst && (fifo_count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  always_comb begin
    of_cnt_d   = of_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (push && OF && (of_cnt_q != SatMax)) begin
      of_cnt_d = of_cnt_q + 16'd1;
    end
    if (in_valid && !in_ready && (drop_cnt_q != SatMax)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= StWaitLock;
      qual_cnt_q <= '0;
      of_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      qual_cnt_q <= qual_cnt_d;
      of_cnt_q   <= of_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .Width (WIDTH + 1),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (refclk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({OF, sum}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  // Outputs read as zero during reset cycles, before the registers have cleared
  always_comb begin
    out_data   = rst ? '0 : fifo_rdata;
    count      = rst ? '0 : fifo_count;
    of_count   = rst ? '0 : of_cnt_q;
    drop_count = rst ? '0 : drop_cnt_q;
  end

endmodule

// File: tb/tb_add_result_buffer.sv
module tb_add_result_buffer;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned QUAL_CYC = 4;

  logic                   refclk = 1'b0;
  logic                   rst;
  logic                   locked;
  logic                   in_valid;
  logic [WIDTH-1:0]       sum;
  logic                   OF;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH:0]         out_data;
  logic [$clog2(DEPTH):0] count;
  logic [15:0]            of_count;
  logic [15:0]            drop_count;

  add_result_buffer #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .QUAL_CYC (QUAL_CYC)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .in_valid   (in_valid),
    .sum        (sum),
    .OF         (OF),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .of_count   (of_count),
    .drop_count (drop_count)
  );

  always #5 refclk = ~refclk;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of expected entries, length of the current locked streak,
  // and the two event counters.
  logic [WIDTH:0] exp_q[$];
  int             streak = 0;
  int             of_m   = 0;
  int             drop_m = 0;
  logic           exp_ready = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares every cycle away from the active edge and pops on output handshake.
  always @(negedge refclk) begin
    logic           exp_valid;
    logic [WIDTH:0] head;
    exp_valid = !rst && (exp_q.size() != 0);
    exp_ready = !rst && (streak >= QUAL_CYC) && (exp_q.size() < DEPTH);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("count", 64'(count), rst ? 64'd0 : 64'(exp_q.size()));
    chk("of_count", 64'(of_count), rst ? 64'd0 : 64'(of_m));
    chk("drop_count", 64'(drop_count), rst ? 64'd0 : 64'(drop_m));
    if (rst) begin
      chk("out_data_rst", 64'(out_data), 64'd0);
    end else if (exp_valid && out_ready) begin
      head = exp_q.pop_front();
      chk("out_data", 64'(out_data), 64'(head));
    end
  end

  // Scoreboard feed: the accepted input becomes an expected output entry.
  always @(posedge refclk) begin
    if (rst) begin
      exp_q.delete();
      streak = 0;
      of_m   = 0;
      drop_m = 0;
    end else begin
      if (in_valid && exp_ready) begin
        exp_q.push_back({OF, sum});
        if (OF && of_m < 65535) of_m++;
      end else if (in_valid && drop_m < 65535) begin
        drop_m++;
      end
      streak = locked ? ((streak < 1000) ? streak + 1 : streak) : 0;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic drive(logic v, logic [WIDTH-1:0] s, logic o);
    in_valid = v;
    sum      = s;
    OF       = o;
  endtask

  task automatic push_n(int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, $urandom, 1'($urandom_range(0, 1)));
      tick();
    end
    drive(1'b0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; locked = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, 1'b0);
    tick(5);
    rst = 1'b0;
    locked = 1'b1;
    tick(6);

    // Three results drained in order with out_ready high
    out_ready = 1'b1;
    drive(1'b1, 32'd30, 1'b0);         tick();
    drive(1'b1, 32'd300, 1'b0);        tick();
    drive(1'b1, 32'h8000_0000, 1'b1);  tick();
    drive(1'b0, '0, 1'b0);
    tick(4);

    // Fill past full with consumer stalled, then drain
    out_ready = 1'b0;
    push_n(5);
    tick(2);
    out_ready = 1'b1;
    tick(6);

    // Simultaneous push and pop at count=2
    out_ready = 1'b0;
    push_n(2);
    out_ready = 1'b1;
    push_n(1);
    tick(4);

    // Lose lock with 3 stored, keep offering data, then relock
    out_ready = 1'b0;
    push_n(3);
    locked = 1'b0;
    drive(1'b1, 32'h1234, 1'b0);
    tick(2);
    out_ready = 1'b1;
    tick(3);
    locked = 1'b1;
    push_n(8);
    tick(4);

    // Reset with 3 entries stored
    out_ready = 1'b0;
    push_n(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(6);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 249) == 0);
      locked    = ($urandom_range(0, 39) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      drive(1'($urandom_range(0, 9) < 6), $urandom, 1'($urandom_range(0, 1)));
      tick();
    end

    // Bounded final drain
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, 1'b0);
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) tick();
    tick(2);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_result_buffer.md
ADD_RESULT_BUFFER -- requirements
Module: add_result_buffer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the adder result width.
REQ-002 Parameter DEPTH, default 4, SHALL set the FIFO entry count; it SHALL be a power of two, at least 2.
REQ-003 Parameter QUAL_CYC, default 4, SHALL set the consecutive locked-high cycles required before accepting data.
REQ-004 refclk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 locked  input  1  SHALL be the PLL lock indication.
REQ-007 in_valid  input  1  SHALL mark sum/OF as a valid adder result.
REQ-008 sum  input  WIDTH  SHALL be the adder sum.
REQ-009 OF  input  1  SHALL be the adder overflow flag.
REQ-010 in_ready  output  1  SHALL indicate the block accepts a result this cycle.
REQ-011 out_valid  output  1  SHALL indicate out_data holds the FIFO head.
REQ-012 out_ready  input  1  SHALL indicate the consumer takes the head this cycle.
REQ-013 out_data  output  WIDTH+1  SHALL be {OF, sum} of the head entry.
REQ-014 count  output  clog2(DEPTH)+1  SHALL be the current occupancy.
REQ-015 of_count  output  16  SHALL count accepted entries with OF=1.
REQ-016 drop_count  output  16  SHALL count cycles with in_valid=1 and in_ready=0.

Function
REQ-017 Lock FSM states: WAIT_LOCK, QUAL, RUN.
REQ-018 WAIT_LOCK -> QUAL when locked=1; QUAL -> RUN after QUAL_CYC consecutive locked=1 cycles; any state -> WAIT_LOCK in the cycle after locked=0.
REQ-019 in_ready SHALL equal (state==RUN) && (count<DEPTH).
REQ-020 Push SHALL occur on in_valid && in_ready; pop on out_valid && out_ready.
REQ-021 out_valid SHALL equal (count!=0); out_data registered, no combinational bypass: push in cycle N is visible at the output in cycle N+1 at the earliest.
REQ-022 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and preserve order.
REQ-023 When full, in_ready=0 even when a pop occurs the same cycle.
REQ-024 Pop while empty SHALL have no effect; out_data is don't-care when out_valid=0.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.
REQ-026 Loss of lock mid-operation SHALL stop acceptance only; stored entries continue to drain.
REQ-027 of_count and drop_count SHALL saturate at 16'hFFFF, never wrap.
REQ-028 out_data order SHALL be strictly FIFO.

Reset
REQ-029 In any cycle with rst=1: state=WAIT_LOCK, qualification counter=0, pointers=0, count=0, out_valid=0, in_ready=0, of_count=0, drop_count=0, out_data=0.
REQ-030 Reset SHALL override simultaneous push/pop; stored entries are discarded.

Structure
REQ-031 Package add_buf_pkg SHALL hold the WIDTH/DEPTH/QUAL_CYC defaults and the lock FSM state type.
REQ-032 Storage and pointers SHALL live in one sub-module, sync_fifo; the lock FSM and counters SHALL live in add_result_buffer.

Verification
REQ-033 rst for 5 cycles, then locked=1 -> in_ready rises exactly 4 cycles after the first locked=1 cycle.
REQ-034 Push sum=30/OF=0, then sum=300/OF=0, then sum=32'h80000000/OF=1, with out_ready=1 -> out_data sequence 33'h0_0000001E, 33'h0_0000012C, 33'h1_80000000; of_count=1.
REQ-035 out_ready=0, push 5 results -> count=4, in_ready=0, drop_count=1; then out_ready=1 -> first 4 results drain in order.
REQ-036 count=2, push and pop in the same cycle -> count stays 2, correct head order.
REQ-037 Drop locked with 3 entries stored -> in_ready=0 next cycle, all 3 entries still drain; relock -> acceptance resumes after 4 qualification cycles.
REQ-038 Assert rst with count=3 -> next cycle count=0, out_valid=0, counters=0.
